rr_mux_arbiter: RTL

- Round-robin arbiter and sequencer that shares one 4:1 output mux between four packet requesters.
- Owns the mux select: picks a requester, holds the grant for a whole packet (valid/ready/last), then releases.
- Forcibly releases a stalled owner after a programmable timeout.
- Sits between four producer channels and a single downstream consumer.

---
 rtl/rr_mux_arbiter_pkg.sv | 11 +
 rtl/rr_mux_arbiter_pick.sv | 31 +++
 rtl/rr_mux_arbiter.sv | 118 +++++++++++
 3 files changed

// File: rtl/rr_mux_arbiter_pkg.sv
// rtl/rr_mux_arbiter_pkg.sv - shared types and helpers for the round-robin mux arbiter
package rr_mux_arb_pkg;
  localparam int N_REQ = 4;
  localparam int SEL_W = 2;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
    return p + SEL_W'(1);
  endfunction
endpackage

// File: rtl/rr_mux_arbiter_pick.sv
// rtl/rr_mux_arbiter_pick.sv - combinational round-robin picker over four requests
module rr_pick4
  import rr_mux_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] ptr,
  output logic             any,
  output logic [SEL_W-1:0] idx
);
  logic [2*N_REQ-1:0] req2;
  logic [N_REQ-1:0]   rot;
  logic [SEL_W-1:0]   off;

  // rot[j] is the request at position ptr+j, so the lowest set bit is the winner
  assign req2 = {req, req};
  assign rot  = req2[ptr +: N_REQ];

  always_comb begin
    off = '0;
    any = 1'b1;
    unique casez (rot)
      4'b???1: off = 2'd0;
      4'b??10: off = 2'd1;
      4'b?100: off = 2'd2;
      4'b1000: off = 2'd3;
      default: any = 1'b0;
    endcase
  end

  assign idx = ptr + off;
endmodule

// File: rtl/rr_mux_arbiter.sv
// rtl/rr_mux_arbiter.sv - packet-granular round-robin owner of a shared 4:1 output mux
module rr_mux_arbiter
  import rr_mux_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [N_REQ-1:0]  valid_in,
  input  logic [N_REQ-1:0]  last_in,
  input  logic [DATA_W-1:0] data_a_in,
  input  logic [DATA_W-1:0] data_b_in,
  input  logic [DATA_W-1:0] data_c_in,
  input  logic [DATA_W-1:0] data_d_in,
  output logic [N_REQ-1:0]  ready_out,
  output logic [DATA_W-1:0] y_data_out,
  output logic              y_valid_out,
  output logic              y_last_out,
  input  logic              y_ready_in,
  output logic [SEL_W-1:0]  sel_out,
  output logic              busy_out,
  output logic              timeout_err_out
);
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  state_t             state_q, state_d;
  logic [N_REQ-1:0]   grant_q, grant_d;
  logic [SEL_W-1:0]   sel_q, sel_d, ptr_q, ptr_d;
  logic [CNT_W-1:0]   tcnt_q, tcnt_d;
  logic               terr_q, terr_d;
  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;
  logic               busy, xfer, timeout_hit;

  rr_pick4 u_pick (
    .req (valid_in),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // The mux follows sel_q even in IDLE so it keeps pointing at the last owner
  always_comb begin
    case (sel_q)
      2'd0:    y_data_out = data_a_in;
      2'd1:    y_data_out = data_b_in;
      2'd2:    y_data_out = data_c_in;
      default: y_data_out = data_d_in;
    endcase
  end

  assign busy            = (state_q == BUSY);
  assign busy_out        = busy;
  assign sel_out         = sel_q;
  assign y_valid_out     = busy & valid_in[sel_q];
  assign y_last_out      = busy & last_in[sel_q];
  assign ready_out       = grant_q & {N_REQ{busy & y_ready_in}};
  assign timeout_err_out = terr_q;
  assign xfer            = y_valid_out & y_ready_in;
  assign timeout_hit     = (TIMEOUT != 0) && busy && !y_valid_out &&
                           (tcnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    sel_d   = sel_q;
    ptr_d   = ptr_q;
    tcnt_d  = tcnt_q;
    terr_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = BUSY;
          sel_d   = pick_idx;
          grant_d = N_REQ'(1) << pick_idx;
          tcnt_d  = '0;
        end
      end
      BUSY: begin
        // A last-beat transfer needs valid high, so it can never coincide with a timeout
        if (xfer && y_last_out) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_inc(sel_q);
        end else if (timeout_hit) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = ptr_inc(sel_q);
          terr_d  = 1'b1;
        end else if (xfer) begin
          tcnt_d  = '0;
        end else if (!y_valid_out) begin
          tcnt_d  = tcnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      grant_q <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      tcnt_q  <= '0;
      terr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      tcnt_q  <= tcnt_d;
      terr_q  <= terr_d;
    end
  end
endmodule
